mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter onto one wait-stated RAM port
//
// Purpose: grants one of two requesters (0 = fetch, 1 = data) access to a
// shared 32-bit RAM, performs byte/halfword/word accesses with lane steering,
// and completes each access with a 4-phase mfa/mfc handshake.
//
// Ports:
//   clk, clr                  clock, asynchronous active-low reset
//   mfa0/1, rw0/1, mas0/1     request, 1=read, size (00 b, 01 h, 10 w, 11 reserved)
//   addr0/1, wdata0/1         byte address, right-justified write data
//   mfc0/1                    completion to each requester
//   rdata, err                read result / fault, valid while an mfc is high
//   ram_en, ram_we, ram_addr  RAM select, write strobe, word-aligned address
//   ram_be, ram_wdata         byte-lane enables, lane-steered write data
//   ram_rdata                 RAM read data
//   busy, gnt                 not-idle flag, owner of the current access
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mfa0,
  input  logic              mfa1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [1:0]        mas0,
  input  logic [1:0]        mas1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              mfc0,
  output logic              mfc1,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy,
  output logic              gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              last;
  logic              l_rw;
  logic [1:0]        l_mas;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;

  logic              win;
  logic              sel_rw;
  logic [1:0]        sel_mas;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_fault;
  logic              mfa_g;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_ext;

  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    if (mfa0 && mfa1) win = ~last;
    else              win = mfa1;
    sel_rw    = win ? rw1    : rw0;
    sel_mas   = win ? mas1   : mas0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
    sel_fault = (sel_mas == 2'b11) ||
                (sel_mas == 2'b01 && sel_addr[0]) ||
                (sel_mas == 2'b10 && sel_addr[1:0] != 2'b00);
  end

  assign mfa_g = gnt ? mfa1 : mfa0;
  assign busy  = (state != IDLE);

  // DONE spends its first cycle raising mfc; it may only leave once mfc has
  // been presented and the owner's mfa is seen low.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mfa0 || mfa1) state_n = sel_fault ? DONE : ACCESS;
      ACCESS:  if (cnt == 4'd0) state_n = DONE;
      DONE:    if ((mfc0 || mfc1) && !mfa_g) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'd0;
    if (state == ACCESS) begin
      ram_en   = 1'b1;
      ram_we   = ~l_rw;
      ram_addr = {l_addr[ADDR_W-1:2], 2'b00};
      case (l_mas)
        2'b00: begin
          ram_be    = 4'b0001 << l_addr[1:0];
          ram_wdata = {4{l_wdata[7:0]}};
        end
        2'b01: begin
          ram_be    = 4'b0011 << l_addr[1:0];
          ram_wdata = {2{l_wdata[15:0]}};
        end
        default: begin
          ram_be    = 4'b1111;
          ram_wdata = l_wdata;
        end
      endcase
    end
  end

  // Little-endian lane extraction: move the addressed lane down to bit 0.
  always_comb begin
    rd_shift = ram_rdata >> {l_addr[1:0], 3'b000};
    case (l_mas)
      2'b00:   rd_ext = {24'd0, rd_shift[7:0]};
      2'b01:   rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      gnt     <= 1'b0;
      mfc0    <= 1'b0;
      mfc1    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
      l_rw    <= 1'b0;
      l_mas   <= 2'b00;
      l_addr  <= '0;
      l_wdata <= 32'd0;
    end else begin
      state <= state_n;
      mfc0  <= (state == DONE) && (state_n == DONE) && !gnt;
      mfc1  <= (state == DONE) && (state_n == DONE) && gnt;
      case (state)
        IDLE: begin
          if (mfa0 || mfa1) begin
            gnt     <= win;
            last    <= win;
            l_rw    <= sel_rw;
            l_mas   <= sel_mas;
            l_addr  <= sel_addr;
            l_wdata <= sel_wdata;
            cnt     <= 4'(WAIT_STATES);
            if (sel_fault) err <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata <= rd_ext;
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          clr;
  logic          mfa0, mfa1, rw0, rw1;
  logic [1:0]    mas0, mas1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          mfc0, mfc1, err, ram_en, ram_we, busy, gnt;
  logic [31:0]   rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;

  logic [31:0]   ram [64];
  logic          poke_en;
  logic [5:0]    poke_idx;
  logic [31:0]   poke_val;

  mem_port_arbiter #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .clr(clr),
    .mfa0(mfa0), .mfa1(mfa1), .rw0(rw0), .rw1(rw1),
    .mas0(mas0), .mas1(mas1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .mfc0(mfc0), .mfc1(mfc1), .rdata(rdata), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr[AW-1:2]];

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_idx] <= poke_val;
    end else if (ram_en && ram_we) begin
      for (int l = 0; l < 4; l++)
        if (ram_be[l]) ram[ram_addr[AW-1:2]][8*l +: 8] <= ram_wdata[8*l +: 8];
    end
  end

  typedef struct {
    int          who;
    bit          rw;
    int          mas;
    int          addr;
    logic [31:0] wdata;
    bit          fault;
    logic [31:0] exp_rdata;
  } txn_t;

  txn_t        sbq[$];
  logic [7:0]  mbytes [256];
  int          last_m;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_bytes(input int mas);
    return (mas == 0) ? 1 : (mas == 1) ? 2 : 4;
  endfunction

  function automatic bit is_fault(input int mas, input int addr);
    if (mas == 3) return 1'b1;
    return (addr % size_bytes(mas)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input txn_t t);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < size_bytes(t.mas); i++)
      if ((t.addr % 4) + i < 4) be[(t.addr % 4) + i] = 1'b1;
    return be;
  endfunction

  // Each lane carries the write-data byte that belongs there, repeated
  // across the lanes for sub-word sizes.
  function automatic logic [31:0] exp_lanes(input txn_t t);
    logic [31:0] v = 32'd0;
    int sz = size_bytes(t.mas);
    int off = t.addr % 4;
    for (int l = 0; l < 4; l++) v[8*l +: 8] = t.wdata[8*((l + 4 - off) % sz) +: 8];
    return v;
  endfunction

  function automatic txn_t mk(input int who, input bit rw, input int mas, input int addr, input logic [31:0] wdata);
    txn_t t;
    t.who = who; t.rw = rw; t.mas = mas; t.addr = addr; t.wdata = wdata;
    t.fault = 1'b0; t.exp_rdata = 32'd0;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int who);
    int mas  = $urandom_range(0, 3);
    int addr = $urandom_range(0, 255);
    if ($urandom_range(0, 3) != 0 && mas != 3) addr = addr & ~(size_bytes(mas) - 1);
    return mk(who, 1'($urandom_range(0, 1)), mas, addr, $urandom);
  endfunction

  task automatic serve(input txn_t t);
    txn_t u = t;
    u.fault = is_fault(t.mas, t.addr);
    u.exp_rdata = 32'd0;
    if (!u.fault) begin
      for (int i = 0; i < size_bytes(t.mas); i++) begin
        if (t.rw) u.exp_rdata[8*i +: 8] = mbytes[t.addr + i];
        else      mbytes[t.addr + i] = t.wdata[8*i +: 8];
      end
    end
    sbq.push_back(u);
  endtask

  task automatic drive(input txn_t t);
    if (t.who == 0) begin
      rw0 = t.rw; mas0 = 2'(t.mas); addr0 = AW'(t.addr); wdata0 = t.wdata;
    end else begin
      rw1 = t.rw; mas1 = 2'(t.mas); addr1 = AW'(t.addr); wdata1 = t.wdata;
    end
  endtask

  task automatic wait_done(input bit chk, input int exp_lat);
    bit ok = 1'b0;
    bit seen = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (mfc0 && mfa0) begin
        if (chk && !seen) check("latency0", n, exp_lat);
        seen = 1'b1;
        mfa0 = 1'b0;
      end
      if (mfc1 && mfa1) begin
        if (chk && !seen) check("latency1", n, exp_lat);
        seen = 1'b1;
        mfa1 = 1'b0;
      end
      if (!mfa0 && !mfa1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got no completion in 80 cycles, required mfc");
      mfa0 = 1'b0;
      mfa1 = 1'b0;
    end
  endtask

  task automatic issue(input bit a0, input bit a1, input txn_t t0, input txn_t t1);
    txn_t s;
    drive(t0);
    drive(t1);
    if (a0 && a1) begin
      if (last_m == 1) begin serve(t0); serve(t1); last_m = 1; end
      else             begin serve(t1); serve(t0); last_m = 0; end
    end else if (a0) begin
      serve(t0); last_m = 0;
    end else begin
      serve(t1); last_m = 1;
    end
    s = a0 ? t0 : t1;
    mfa0 = a0;
    mfa1 = a1;
    wait_done(!(a0 && a1), is_fault(s.mas, s.addr) ? 2 : WS + 3);
    @(negedge clk);
  endtask

  // Monitor: checks RAM-side activity against the head of the scoreboard and
  // pops one entry per rising mfc.
  int   en_cnt = 0;
  bit   prev_mfc = 1'b0;
  txn_t mt;

  always @(negedge clk) begin
    if (!clr) begin
      en_cnt   = 0;
      prev_mfc = 1'b0;
    end else begin
      if (ram_en) begin
        en_cnt++;
        if (sbq.size() > 0) begin
          mt = sbq[0];
          check("ram_we", ram_we, !mt.rw);
          check("ram_be", ram_be, exp_be(mt));
          check("ram_addr", ram_addr, 32'(mt.addr & 'hFC));
          if (!mt.rw) check("ram_wdata", ram_wdata, exp_lanes(mt));
        end
      end else begin
        check("idle_strobes", {ram_we, ram_be}, 32'd0);
      end
      if ((mfc0 || mfc1) && !prev_mfc) begin
        check("mfc_exclusive", mfc0 && mfc1, 1'b0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mfc: got mfc0=%0d mfc1=%0d with nothing outstanding", mfc0, mfc1);
        end else begin
          mt = sbq.pop_front();
          check("owner", mfc1, mt.who == 1);
          check("err", err, mt.fault);
          if (!mt.fault && mt.rw) check("rdata", rdata, mt.exp_rdata);
          check("ram_cycles", en_cnt, mt.fault ? 0 : WS + 1);
        end
        en_cnt = 0;
      end
      prev_mfc = mfc0 || mfc1;
    end
  end

  initial begin
    txn_t t0, t1;
    int hi;
    int mask;
    clr = 1'b0;
    mfa0 = 1'b0; mfa1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    mas0 = 2'b00; mas1 = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = 32'd0; wdata1 = 32'd0;
    poke_en = 1'b0; poke_idx = 6'd0; poke_val = 32'd0;
    last_m = 1;

    #1;
    check("rst_mfc0", mfc0, 0);
    check("rst_mfc1", mfc1, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_be", ram_be, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);

    poke_en = 1'b1;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      poke_idx = 6'(w);
      poke_val = (w == 4) ? 32'hDEADBEEF : (w == 0) ? 32'h8001FFFF : $urandom;
      for (int b = 0; b < 4; b++) mbytes[4*w + b] = poke_val[8*b +: 8];
    end
    @(negedge clk);
    poke_en = 1'b0;
    clr = 1'b1;
    @(negedge clk);

    // Two simultaneous pairs straight out of reset: 0,1 then 0,1 again.
    issue(1'b1, 1'b1, mk(0, 1'b1, 2, 'h40, 0), mk(1, 1'b1, 2, 'h44, 0));
    issue(1'b1, 1'b1, mk(0, 1'b1, 0, 'h49, 0), mk(1, 1'b1, 1, 'h4E, 0));

    issue(1'b1, 1'b0, mk(0, 1'b1, 2, 'h10, 0), mk(1, 1'b0, 0, 0, 0));
    check("word_read_value", rdata, 32'hDEADBEEF);
    issue(1'b0, 1'b1, mk(0, 1'b0, 0, 0, 0), mk(1, 1'b0, 0, 'h07, 32'h000000A5));
    issue(1'b1, 1'b0, mk(0, 1'b1, 1, 'h03, 0), mk(1, 1'b0, 0, 0, 0));
    issue(1'b1, 1'b0, mk(0, 1'b1, 3, 'h20, 0), mk(1, 1'b0, 0, 0, 0));
    issue(1'b1, 1'b0, mk(0, 1'b1, 1, 'h02, 0), mk(1, 1'b0, 0, 0, 0));
    check("half_read_value", rdata, 32'h00008001);

    // Requester gives up during ACCESS: the access still finishes and mfc
    // is shown for exactly one cycle.
    t0 = mk(0, 1'b1, 2, 'h10, 0);
    drive(t0);
    serve(t0);
    last_m = 0;
    mfa0 = 1'b1;
    @(negedge clk);
    mfa0 = 1'b0;
    hi = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mfc0) hi++;
    end
    check("dropped_mfc_width", hi, 1);
    check("dropped_back_idle", busy, 0);

    // Reset in the middle of ACCESS, then a full retry of the held request.
    t0 = mk(0, 1'b1, 2, 'h20, 0);
    drive(t0);
    mfa0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_en", ram_en, 1);
    #1 clr = 1'b0;
    #1;
    check("abort_ram_en", ram_en, 0);
    check("abort_busy", busy, 0);
    check("abort_mfc0", mfc0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 clr = 1'b1;
    last_m = 1;
    serve(t0);
    last_m = 0;
    wait_done(1'b1, WS + 3);
    @(negedge clk);

    for (int k = 0; k < 50; k++) begin
      mask = $urandom_range(1, 3);
      t0 = rand_txn(0);
      t1 = rand_txn(1);
      issue((mask & 1) != 0, (mask & 2) != 0, t0, t1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
